// File: rtl/neuron_mac_stream.sv
// neuron_mac_stream: streaming multiply-accumulate neuron.
// Takes a vector as LANES-wide valid/ready beats and accumulates bias + sum(x*w).
// It then rounds and shifts, applies the activation and saturates, and returns one result per vector.
// Optional feature macro: NEURON_MAC_LEAKY_EN. When defined, act_mode=10 selects leaky ReLU (r>>>3 for r<0).
module neuron_mac_stream #(
    parameter int DATA_W    = 8,
    parameter int LANES     = 4,
    parameter int ACC_W     = 32,
    parameter int BIAS_W    = 16,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [LANES*DATA_W-1:0]   in_x,
    input  logic [LANES*DATA_W-1:0]   in_w,
    input  logic [BIAS_W-1:0]         bias,
    input  logic [1:0]                act_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_sat
);

    localparam int PW = 2 * DATA_W;
    // One guard bit, so the rounding add cannot wrap before the shift.
    localparam int RW = ACC_W + 1;
    localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_HOLD} state_t;

    state_t                    r_state;
    logic                      r_first;
    logic                      r_out_valid;
    logic [OUT_W-1:0]          r_out_data;
    logic                      r_out_sat;

    // r_vld_pipe[0]: S1 holds an accepted beat; r_vld_pipe[1]: S2 holds a completed vector.
    logic [1:0]                r_vld_pipe;
    logic [LANES-1:0][PW-1:0]  r_prod;
    logic                      r_s1_last;
    logic                      r_s1_first;
    logic [ACC_W-1:0]          r_bias_ext;
    logic [1:0]                r_mode;
    logic [ACC_W-1:0]          r_acc;

    logic                      w_accept;
    logic [LANES-1:0][PW-1:0]  w_prod;
    logic [ACC_W-1:0]          w_lane_sum;
    logic signed [RW-1:0]      w_r;
    logic signed [RW-1:0]      w_act;
    logic                      w_sat;
    logic [OUT_W-1:0]          w_out;

    // in_ready is held low during reset, so no beat can be taken while reset is asserted.
    assign in_ready  = reset_n && (r_state == ST_ACCUM);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_prod[g] = $signed(in_x[g*DATA_W +: DATA_W]) * $signed(in_w[g*DATA_W +: DATA_W]);
    end

    // Sum the S1 lane products, with each product sign-extended to the accumulator width.
    always_comb begin
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++)
            w_lane_sum = w_lane_sum + {{(ACC_W-PW){r_prod[l][PW-1]}}, r_prod[l]};
    end

    if (OUT_SHIFT > 0) begin : g_shift
        localparam logic signed [RW-1:0] HALF = RW'(1) <<< (OUT_SHIFT - 1);
        assign w_r = ($signed({r_acc[ACC_W-1], r_acc}) + HALF) >>> OUT_SHIFT;
    end else begin : g_noshift
        assign w_r = $signed({r_acc[ACC_W-1], r_acc});
    end

    // Apply the activation, then clip to the OUT_W signed range.
    always_comb begin
        w_act = w_r;
        case (r_mode)
            2'b01:   if (w_r < 0) w_act = '0;
`ifdef NEURON_MAC_LEAKY_EN
            2'b10:   if (w_r < 0) w_act = w_r >>> 3;
`endif
            default: w_act = w_r;
        endcase
        w_sat = (w_act > MAXV) || (w_act < MINV);
        if (w_act > MAXV)      w_out = MAXV[OUT_W-1:0];
        else if (w_act < MINV) w_out = MINV[OUT_W-1:0];
        else                   w_out = w_act[OUT_W-1:0];
    end

    // S1 captures the products. S2 accumulates them, and a first beat restarts the accumulator from the bias.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_prod     <= '0;
            r_s1_last  <= 1'b0;
            r_s1_first <= 1'b0;
            r_bias_ext <= '0;
            r_mode     <= '0;
            r_acc      <= '0;
        end else begin
            r_vld_pipe[0] <= w_accept;
            r_vld_pipe[1] <= r_vld_pipe[0] && r_s1_last;
            if (w_accept) begin
                r_prod     <= w_prod;
                r_s1_last  <= in_last;
                r_s1_first <= r_first;
                if (r_first) begin
                    r_bias_ext <= {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
                    r_mode     <= act_mode;
                end
            end
            if (r_vld_pipe[0])
                r_acc <= r_s1_first ? (r_bias_ext + w_lane_sum) : (r_acc + w_lane_sum);
        end
    end

    // Vector sequencing: accumulate, drain the pipe, hold the result until it is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_ACCUM;
            r_first     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_first <= 1'b0;
                        if (in_last) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_vld_pipe[1]) begin
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_out;
                        r_out_sat   <= w_sat;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_out_valid <= 1'b0;
                        r_first     <= 1'b1;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_stream.sv
// Bench for neuron_mac_stream. It runs two instances in lock-step: OUT_SHIFT=0 and OUT_SHIFT=4.
// Stimulus comes from directed table vectors, hand-written corner sequences and random vectors.
// The random vectors are checked against an arithmetic reference model.
module tb_neuron_mac_stream;
    localparam int DW = 8;
    localparam int LN = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid, in_last, out_ready;
    logic [LN*DW-1:0] in_x, in_w;
    logic [15:0]     bias;
    logic [1:0]      act_mode;
    logic            in_ready, out_valid, out_sat;
    logic            in_ready4, out_valid4, out_sat4;
    logic [15:0]     out_data, out_data4;

    neuron_mac_stream #(.OUT_SHIFT(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_x(in_x), .in_w(in_w), .bias(bias), .act_mode(act_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat));

    neuron_mac_stream #(.OUT_SHIFT(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4), .in_last(in_last),
        .in_x(in_x), .in_w(in_w), .bias(bias), .act_mode(act_mode), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .out_sat(out_sat4));

    int n_cmp = 0;
    int n_bad = 0;

    // Current vector
    int vnb, vbias, vmode;
    int vx [16][4];
    int vw [16][4];

    typedef struct {
        int nb;
        int x [4];
        int w [4];
        int bias;
        int mode;
        int e0; bit s0;
        int e4; bit s4;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int nb, input int x0, x1, x2, x3, input int w0, w1, w2, w3,
                                input int b, m, e0, input bit s0, input int e4, input bit s4);
        vec_t r;
        r.nb = nb;
        r.x[0] = x0; r.x[1] = x1; r.x[2] = x2; r.x[3] = x3;
        r.w[0] = w0; r.w[1] = w1; r.w[2] = w2; r.w[3] = w3;
        r.bias = b; r.mode = m; r.e0 = e0; r.s0 = s0; r.e4 = e4; r.s4 = s4;
        return r;
    endfunction

    task automatic load_row(input vec_t r);
        vnb = r.nb; vbias = r.bias; vmode = r.mode;
        for (int b = 0; b < r.nb; b++)
            for (int l = 0; l < LN; l++) begin
                vx[b][l] = r.x[l];
                vw[b][l] = r.w[l];
            end
    endtask

    task automatic load_simple(input int nb, input int x, input int w, input int b, input int m);
        vnb = nb; vbias = b; vmode = m;
        for (int i = 0; i < nb; i++)
            for (int l = 0; l < LN; l++) begin
                vx[i][l] = x;
                vw[i][l] = w;
            end
    endtask

    // Reference: the vector's dot product plus bias, wrapped to 32 bits.
    // The result is then rounded and shifted, activated and clipped to 16 bits.
    function automatic void model(input int sh, output int d, output bit s);
        longint acc, r;
        acc = vbias;
        for (int b = 0; b < vnb; b++)
            for (int l = 0; l < LN; l++)
                acc += longint'(vx[b][l]) * longint'(vw[b][l]);
        acc = longint'(int'(acc));
        if (sh > 0) r = (acc + (longint'(1) << (sh - 1))) >>> sh;
        else        r = acc;
        if (vmode == 1 && r < 0) r = 0;
`ifdef NEURON_MAC_LEAKY_EN
        if (vmode == 2 && r < 0) r = r >>> 3;
`endif
        s = (r > 32767) || (r < -32768);
        if (r > 32767)       d = 32767;
        else if (r < -32768) d = -32768;
        else                 d = int'(r);
    endfunction

    // Drive beat b of the current vector, or random junk when valid=0.
    task automatic drive_in(input int b, input bit v);
        in_valid = v;
        if (v) begin
            for (int l = 0; l < LN; l++) begin
                in_x[l*DW +: DW] = 8'(vx[b][l]);
                in_w[l*DW +: DW] = 8'(vw[b][l]);
            end
            in_last  = (b == vnb - 1);
            bias     = (b == 0) ? 16'(vbias) : 16'($urandom);
            act_mode = (b == 0) ? 2'(vmode) : 2'($urandom);
        end else begin
            in_x = $urandom; in_w = $urandom;
            in_last = 1'($urandom_range(1));
            bias = 16'($urandom); act_mode = 2'($urandom);
        end
    endtask

    task automatic drive_beats(input bit rnd, output bit ok);
        int b, n;
        bit v;
        b = 0; n = 0;
        while (b < vnb && n < 300) begin
            v = rnd ? ($urandom_range(3) != 0) : 1'b1;
            drive_in(b, v);
            out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) b++;
            @(posedge clk); #1;
            n++;
        end
        ok = (b == vnb);
    endtask

    // hold<0: random out_ready; hold>=0: out_ready low for that many cycles of out_valid.
    task automatic wait_result(input int hold, output int d0, output bit s0, output int d4, output bit s4,
                               output int lat, output bit stable, output bit ok);
        int n, held;
        bit seen;
        logic [15:0] f0, f4;
        n = 1; held = 0; seen = 0; ok = 0; stable = 1; lat = 0;
        d0 = 0; s0 = 0; d4 = 0; s4 = 0; f0 = '0; f4 = '0;
        while (!ok && n < 60) begin
            in_valid = 1'($urandom_range(1)); in_last = 1'($urandom_range(1));
            in_x = $urandom; in_w = $urandom; bias = 16'($urandom); act_mode = 2'($urandom);
            if (hold < 0) out_ready = 1'($urandom_range(1));
            else          out_ready = seen ? (held >= hold) : (hold == 0);
            @(negedge clk);
            if (out_valid !== out_valid4 || in_ready !== in_ready4) stable = 0;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1; lat = n; f0 = out_data; f4 = out_data4;
                end else if (out_data !== f0 || out_data4 !== f4) stable = 0;
                if (in_ready) stable = 0;
                if (out_ready) begin
                    ok = 1;
                    d0 = int'($signed(out_data)); s0 = out_sat;
                    d4 = int'($signed(out_data4)); s4 = out_sat4;
                end else held++;
            end else if (seen) stable = 0;
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        bit ok, ok2, stable, stale, s0, s4, es0, es4;
        int d0, d4, lat, ed0, ed4;

        in_valid = 0; in_last = 0; in_x = '0; in_w = '0; bias = '0; act_mode = '0; out_ready = 1;

        tbl[0]  = mk(1,    1,   2,   3,   4,   5,   6,   7,   8,     10, 0,     80, 0,      5, 0);
        tbl[1]  = mk(3,  127, 127, 127, 127, 127, 127, 127, 127,      0, 0,  32767, 1,  12097, 0);
        tbl[2]  = mk(3, -128,-128,-128,-128, 127, 127, 127, 127,      0, 0, -32768, 1, -12192, 0);
        tbl[3]  = mk(1,   -5,   0,   0,   0,  10,   0,   0,   0,      0, 1,      0, 0,      0, 0);
`ifdef NEURON_MAC_LEAKY_EN
        tbl[4]  = mk(1,   -5,   0,   0,   0,  10,   0,   0,   0,      0, 2,     -7, 0,     -1, 0);
`else
        tbl[4]  = mk(1,   -5,   0,   0,   0,  10,   0,   0,   0,      0, 2,    -50, 0,     -3, 0);
`endif
        tbl[5]  = mk(1,   -5,   0,   0,   0,  10,   0,   0,   0,      0, 0,    -50, 0,     -3, 0);
        tbl[6]  = mk(1,   -5,   0,   0,   0,  10,   0,   0,   0,      0, 3,    -50, 0,     -3, 0);
        tbl[7]  = mk(1,    0,   0,   0,   0,   0,   0,   0,   0,     40, 0,     40, 0,      3, 0);
        tbl[8]  = mk(1,    0,   0,   0,   0,   0,   0,   0,   0,    -40, 0,    -40, 0,     -2, 0);
        tbl[9]  = mk(1,    0,   0,   0,   0,   0,   0,   0,   0,     24, 0,     24, 0,      2, 0);
        tbl[10] = mk(1,    0,   0,   0,   0,   0,   0,   0,   0, -32768, 0, -32768, 0,  -2048, 0);
        tbl[11] = mk(2,  100, 100, 100, 100, 100, 100, 100, 100,   1000, 1,  32767, 1,   5063, 0);

        // Reset state
        #2;
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_sat", out_sat, 0);
        check("rst in_ready", in_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        check("in_ready after reset", in_ready, 1);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            load_row(tbl[i]);
            drive_beats(0, ok);
            wait_result(0, d0, s0, d4, s4, lat, stable, ok2);
            check($sformatf("tbl%0d beats", i), ok, 1);
            check($sformatf("tbl%0d done", i), ok2, 1);
            check($sformatf("tbl%0d data", i), d0, tbl[i].e0);
            check($sformatf("tbl%0d sat", i), s0, tbl[i].s0);
            check($sformatf("tbl%0d data_sh4", i), d4, tbl[i].e4);
            check($sformatf("tbl%0d sat_sh4", i), s4, tbl[i].s4);
            check($sformatf("tbl%0d latency", i), lat, 3);
        end

        // Backpressure: result held 10 cycles, then the next vector reloads the bias
        load_simple(2, 3, 2, 100, 0);
        drive_beats(0, ok);
        wait_result(10, d0, s0, d4, s4, lat, stable, ok2);
        check("bp done", ok2, 1);
        check("bp data", d0, 148);
        check("bp data_sh4", d4, 9);
        check("bp stable", stable, 1);
        @(negedge clk);
        check("bp in_ready after handshake", in_ready, 1);
        @(posedge clk); #1;
        load_simple(1, 0, 0, -3, 0);
        drive_beats(0, ok);
        wait_result(0, d0, s0, d4, s4, lat, stable, ok2);
        check("bp next done", ok2, 1);
        check("bp next data", d0, -3);
        check("bp next data_sh4", d4, 0);

        // Reset after 2 of 3 beats
        load_simple(3, 9, 9, 500, 0);
        for (int b = 0; b < 2; b++) begin
            drive_in(b, 1'b1);
            @(posedge clk); #1;
        end
        reset_n = 0;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst out_data", out_data, 0);
        check("midrst in_ready", in_ready, 0);
        in_valid = 0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale = 1;
            @(posedge clk); #1;
        end
        check("midrst no stale result", stale, 0);
        load_simple(1, 1, 1, 7, 0);
        drive_beats(0, ok);
        wait_result(0, d0, s0, d4, s4, lat, stable, ok2);
        check("midrst next done", ok2, 1);
        check("midrst next data", d0, 11);
        check("midrst next data_sh4", d4, 1);

        // Random vectors against the model
        for (int i = 0; i < 40; i++) begin
            vnb = $urandom_range(5, 1);
            vbias = $urandom_range(65535) - 32768;
            vmode = $urandom_range(3);
            for (int b = 0; b < vnb; b++)
                for (int l = 0; l < LN; l++) begin
                    vx[b][l] = $urandom_range(255) - 128;
                    vw[b][l] = $urandom_range(255) - 128;
                end
            model(0, ed0, es0);
            model(4, ed4, es4);
            drive_beats(1, ok);
            wait_result(-1, d0, s0, d4, s4, lat, stable, ok2);
            check($sformatf("rnd%0d done", i), ok && ok2, 1);
            check($sformatf("rnd%0d data", i), d0, ed0);
            check($sformatf("rnd%0d sat", i), s0, es0);
            check($sformatf("rnd%0d data_sh4", i), d4, ed4);
            check($sformatf("rnd%0d sat_sh4", i), s4, es4);
            check($sformatf("rnd%0d stable", i), stable, 1);
            check($sformatf("rnd%0d latency", i), lat, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
